// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with registered clk_out and a per-period tick.
// Define CLK_DIV_DUTY_EN to add a programmable high time (duty_val port).
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
`ifdef CLK_DIV_DUTY_EN
   input  logic [WIDTH-1:0] duty_val,
`endif
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [WIDTH-1:0] div_active
);

   localparam int               DEF_DIV_I = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
   localparam logic [WIDTH-1:0] DEF_DIV   = WIDTH'(DEF_DIV_I);
`ifdef CLK_DIV_DUTY_EN
   localparam logic [WIDTH-1:0] DEF_DUTY  = WIDTH'((DEF_DIV_I + 1) / 2);
`endif

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_div, w_div_nxt;
   logic [WIDTH-1:0] r_pend_div, w_pend_div_nxt;
   logic             r_pend, w_pend_nxt;
   logic             r_clk, w_clk_nxt;
   logic             r_tick, w_tick_nxt;
   logic [WIDTH-1:0] w_div_ld;
   logic [WIDTH-1:0] w_cnt_inc;
   logic [WIDTH-1:0] w_high;
   logic             w_bound;
`ifdef CLK_DIV_DUTY_EN
   logic [WIDTH-1:0] r_duty, w_duty_nxt;
   logic [WIDTH-1:0] r_pend_duty, w_pend_duty_nxt;
`endif

   assign w_div_ld  = (div_val < WIDTH'(2)) ? WIDTH'(2) : div_val;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_bound   = (r_state != IDLE) && (r_cnt == r_div - 1'b1);

   // High time is clamped against the divisor in force, which only moves on a boundary.
`ifdef CLK_DIV_DUTY_EN
   always_comb begin
      w_high = r_duty;
      if (r_duty == '0)        w_high = WIDTH'(1);
      else if (r_duty >= r_div) w_high = r_div - 1'b1;
   end
`else
   assign w_high = (r_div >> 1) + WIDTH'(r_div[0]);
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_div_nxt      = r_div;
      w_pend_div_nxt = r_pend_div;
      w_pend_nxt     = r_pend;
      w_clk_nxt      = 1'b0;
      w_tick_nxt     = 1'b0;
`ifdef CLK_DIV_DUTY_EN
      w_duty_nxt      = r_duty;
      w_pend_duty_nxt = r_pend_duty;
`endif
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (div_load) begin
               w_div_nxt  = w_div_ld;
               w_pend_nxt = 1'b0;
`ifdef CLK_DIV_DUTY_EN
               w_duty_nxt = duty_val;
`endif
            end
            if (en) begin
               w_state_nxt = RUN;
               w_clk_nxt   = 1'b1;
               w_tick_nxt  = 1'b1;
            end
         end
         default: begin
            if (w_bound) begin
               // A load in the boundary cycle itself beats any older pending value.
               w_cnt_nxt  = '0;
               w_pend_nxt = 1'b0;
               if (div_load) begin
                  w_div_nxt = w_div_ld;
`ifdef CLK_DIV_DUTY_EN
                  w_duty_nxt = duty_val;
`endif
               end else if (r_pend) begin
                  w_div_nxt = r_pend_div;
`ifdef CLK_DIV_DUTY_EN
                  w_duty_nxt = r_pend_duty;
`endif
               end
               if (r_state == STOPPING && !en) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = en ? RUN : STOPPING;
                  w_clk_nxt   = 1'b1;
                  w_tick_nxt  = 1'b1;
               end
            end else begin
               w_cnt_nxt   = w_cnt_inc;
               w_clk_nxt   = (w_cnt_inc < w_high);
               w_state_nxt = en ? RUN : STOPPING;
               if (div_load) begin
                  w_pend_div_nxt = w_div_ld;
                  w_pend_nxt     = 1'b1;
`ifdef CLK_DIV_DUTY_EN
                  w_pend_duty_nxt = duty_val;
`endif
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_div      <= DEF_DIV;
         r_pend_div <= DEF_DIV;
         r_pend     <= 1'b0;
         r_clk      <= 1'b0;
         r_tick     <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
         r_duty      <= DEF_DUTY;
         r_pend_duty <= DEF_DUTY;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_div      <= w_div_nxt;
         r_pend_div <= w_pend_div_nxt;
         r_pend     <= w_pend_nxt;
         r_clk      <= w_clk_nxt;
         r_tick     <= w_tick_nxt;
`ifdef CLK_DIV_DUTY_EN
         r_duty      <= w_duty_nxt;
         r_pend_duty <= w_pend_duty_nxt;
`endif
      end
   end

   assign clk_out    = r_clk;
   assign tick       = r_tick;
   assign busy       = (r_state != IDLE);
   assign div_active = r_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios then random traffic, checked against a
// period-queue reference model (each period is expanded into its expected samples).
module tb_clk_div_prog;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic         div_load = 1'b0;
   logic [W-1:0] div_val = '0;
`ifdef CLK_DIV_DUTY_EN
   logic [W-1:0] duty_val = '0;
`endif
   logic         clk_out, tick, busy;
   logic [W-1:0] div_active;

   clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .div_val    (div_val),
      .div_load   (div_load),
`ifdef CLK_DIV_DUTY_EN
      .duty_val   (duty_val),
`endif
      .clk_out    (clk_out),
      .tick       (tick),
      .busy       (busy),
      .div_active (div_active)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic c; logic t; } smp_t;
   smp_t m_q[$];
   int   m_div, m_pend;
   bit   m_busy, m_stopping, m_have;
`ifdef CLK_DIV_DUTY_EN
   int   m_duty, m_pend_duty;
`endif
   int   n_chk = 0, n_pass = 0, n_fail = 0;

   function automatic int clampd(input logic [W-1:0] v);
      return (v < 2) ? 2 : int'(v);
   endfunction

   function automatic int m_cnt();
      return m_div - m_q.size();
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_div = 2; m_pend = 2; m_busy = 0; m_stopping = 0; m_have = 0;
`ifdef CLK_DIV_DUTY_EN
      m_duty = 1; m_pend_duty = 1;
`endif
   endtask

   task automatic m_fill();
      int h;
`ifdef CLK_DIV_DUTY_EN
      h = m_duty;
      if (h < 1) h = 1;
      if (h > m_div - 1) h = m_div - 1;
`else
      h = (m_div + 1) / 2;
`endif
      m_q.delete();
      for (int i = 0; i < m_div; i++) m_q.push_back('{c: (i < h), t: (i == 0)});
   endtask

   // One clock edge of the reference: loads land at once when idle, else at the next period start.
   task automatic m_edge();
      bit last;
      if (!m_busy) begin
         if (div_load) begin
            m_div = clampd(div_val);
`ifdef CLK_DIV_DUTY_EN
            m_duty = int'(duty_val);
`endif
         end
         if (en) begin m_busy = 1; m_stopping = 0; m_fill(); end
      end else begin
         last = (m_q.size() == 1);
         if (div_load) begin
            m_pend = clampd(div_val); m_have = 1;
`ifdef CLK_DIV_DUTY_EN
            m_pend_duty = int'(duty_val);
`endif
         end
         void'(m_q.pop_front());
         if (last) begin
            if (m_have) begin
               m_div = m_pend;
`ifdef CLK_DIV_DUTY_EN
               m_duty = m_pend_duty;
`endif
            end
            m_have = 0;
            if (m_stopping && !en) m_busy = 0;
            else begin m_stopping = !en; m_fill(); end
         end else begin
            m_stopping = !en;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("clk_out",    32'(clk_out),    (m_busy && m_q.size() > 0) ? 32'(m_q[0].c) : 32'd0);
      chk("tick",       32'(tick),       (m_busy && m_q.size() > 0) ? 32'(m_q[0].t) : 32'd0);
      chk("busy",       32'(busy),       32'(m_busy));
      chk("div_active", 32'(div_active), 32'(m_div));
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic load(input int d);
      div_val = W'(d); div_load = 1'b1;
      step();
      div_load = 1'b0;
   endtask

   task automatic run_until_cnt(input int d, input int c);
      for (int i = 0; i < 600 && !(m_busy && m_div == d && m_cnt() == c); i++) step();
   endtask

   initial begin
      m_reset();
      // Reset held with en high: outputs stay at reset values.
      en = 1'b1; reset = 1'b0;
      repeat (3) @(negedge clk);
      check_all();
      reset = 1'b1;
      repeat (8) step();                       // D=2 toggling
      load(5);       repeat (14) step();       // D=5
      load(6);       run_until_cnt(6, 2);
      load(4);       repeat (14) step();       // mid-period change
      load(0);       repeat (8) step();
      load(1);       repeat (8) step();
      load(255);     repeat (520) step();
      load(6);       run_until_cnt(6, 1);
      en = 1'b0;     repeat (8) step();        // stop completes period, then idle
      en = 1'b1;     run_until_cnt(6, 3);
      en = 1'b0;     step(); step();
      en = 1'b1;     repeat (10) step();       // re-raise during STOPPING
      run_until_cnt(6, 1);
      #2 reset = 1'b0;                         // asynchronous reset mid-period
      #1 m_reset();
      check_all();
      @(negedge clk); reset = 1'b1;
      repeat (4) step();
`ifdef CLK_DIV_DUTY_EN
      duty_val = W'(1); load(8); repeat (20) step();
      duty_val = W'(9); load(8); repeat (20) step();
      duty_val = W'(0); load(8); repeat (20) step();
`endif
      for (int i = 0; i < 2000; i++) begin
         int r;
         en       = ($urandom_range(0, 11) != 0);
         div_load = ($urandom_range(0, 7) == 0);
         r        = $urandom_range(0, 49);
         div_val  = (r == 0) ? W'(255) : W'($urandom_range(0, 12));
`ifdef CLK_DIV_DUTY_EN
         duty_val = W'($urandom_range(0, 14));
`endif
         step();
      end
      div_load = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
